// File: rtl/btb_tagged_2way.sv
// Tagged 2-way set-associative branch target buffer for the RV32I fetch stage.
// Each entry holds a valid bit, tag, target and a 2-bit saturating direction
// counter. Each set has one LRU bit that names the way to evict next.
// Lookups return their result one cycle later. Resolved outcomes from EX are
// written in the same cycle. A lookup on that cycle sees the post-update state.
module btb_tagged_2way #(
  parameter int         INDEX_BITS = 6,
  parameter int         TAG_BITS   = 24,  // INDEX_BITS + TAG_BITS must be <= 30
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int SETS = 1 << INDEX_BITS;

  // Saturating 2-bit direction counter step: no wrap at 0 or 3.
  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != 2'b11)
      r = c + 2'b01;
    else if (!up && c != 2'b00)
      r = c - 2'b01;
    return r;
  endfunction

  // Control state (reset) and entry payload (not reset).
  logic [SETS-1:0]     vld_q [2];
  logic [SETS-1:0]     lru_q;
  logic [TAG_BITS-1:0] tag_q [2][SETS];
  logic [31:0]         tgt_q [2][SETS];
  logic [1:0]          ctr_q [2][SETS];

  // pc[1:0] and any bits above the tag never take part in matching.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  // ---- stage p0: update decode (set/tag match, victim choice, new entry) ----
  logic [INDEX_BITS-1:0] u_idx_p0;
  logic [TAG_BITS-1:0]   u_tag_p0;
  logic                  u_hit0_p0, u_hit1_p0;
  logic                  wr_en_p0;
  logic                  wr_way_p0;
  logic [1:0]            wr_ctr_p0;

  assign u_idx_p0 = upd_pc[INDEX_BITS+1:2];
  assign u_tag_p0 = upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Resolve hit/miss for the update and pick the way and counter to write.
  always_comb begin
    u_hit0_p0 = vld_q[0][u_idx_p0] && (tag_q[0][u_idx_p0] == u_tag_p0);
    u_hit1_p0 = vld_q[1][u_idx_p0] && (tag_q[1][u_idx_p0] == u_tag_p0);
    wr_en_p0  = 1'b0;
    wr_way_p0 = 1'b0;
    wr_ctr_p0 = CTR_INIT;
    if (upd_valid) begin
      if (u_hit0_p0) begin
        wr_en_p0  = 1'b1;
        wr_way_p0 = 1'b0;
        wr_ctr_p0 = ctr_sat(ctr_q[0][u_idx_p0], upd_taken);
      end else if (u_hit1_p0) begin
        wr_en_p0  = 1'b1;
        wr_way_p0 = 1'b1;
        wr_ctr_p0 = ctr_sat(ctr_q[1][u_idx_p0], upd_taken);
      end else if (upd_taken) begin
        // Only taken branches allocate; fill empty ways before evicting.
        wr_en_p0 = 1'b1;
        if (!vld_q[0][u_idx_p0])
          wr_way_p0 = 1'b0;
        else if (!vld_q[1][u_idx_p0])
          wr_way_p0 = 1'b1;
        else
          wr_way_p0 = lru_q[u_idx_p0];
        wr_ctr_p0 = CTR_INIT;
      end
    end
  end

  // ---- stage p0: lookup against post-update (write-first) view of the set ----
  logic [INDEX_BITS-1:0] l_idx_p0;
  logic [TAG_BITS-1:0]   l_tag_p0;
  logic                  l_hit_p0   [2];
  logic                  l_taken_p0 [2];
  logic [31:0]           l_tgt_p0   [2];
  logic                  hit_nx_p0;
  logic                  taken_nx_p0;
  logic [31:0]           tgt_nx_p0;

  assign l_idx_p0 = lookup_pc[INDEX_BITS+1:2];
  assign l_tag_p0 = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Per-way match, substituting the entry being written this cycle.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      if (wr_en_p0 && (wr_way_p0 == 1'(w)) && (u_idx_p0 == l_idx_p0)) begin
        l_hit_p0[w]   = (u_tag_p0 == l_tag_p0);
        l_taken_p0[w] = wr_ctr_p0[1];
        l_tgt_p0[w]   = upd_target;
      end else begin
        l_hit_p0[w]   = vld_q[w][l_idx_p0] && (tag_q[w][l_idx_p0] == l_tag_p0);
        l_taken_p0[w] = ctr_q[w][l_idx_p0][1];
        l_tgt_p0[w]   = tgt_q[w][l_idx_p0];
      end
    end
  end

  // Way select; way 0 takes priority should both ways ever match.
  always_comb begin
    hit_nx_p0   = 1'b0;
    taken_nx_p0 = 1'b0;
    tgt_nx_p0   = 32'h0;
    if (l_hit_p0[0]) begin
      hit_nx_p0   = 1'b1;
      taken_nx_p0 = l_taken_p0[0];
      tgt_nx_p0   = l_tgt_p0[0];
    end else if (l_hit_p0[1]) begin
      hit_nx_p0   = 1'b1;
      taken_nx_p0 = l_taken_p0[1];
      tgt_nx_p0   = l_tgt_p0[1];
    end
  end

  // Valid and LRU bits: cleared by reset, set/steered by updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q[0] <= '0;
      vld_q[1] <= '0;
      lru_q    <= '0;
    end else if (wr_en_p0) begin
      vld_q[wr_way_p0][u_idx_p0] <= 1'b1;
      lru_q[u_idx_p0]            <= ~wr_way_p0;
    end
  end

  // Entry payload; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_p0) begin
      tag_q[wr_way_p0][u_idx_p0] <= u_tag_p0;
      tgt_q[wr_way_p0][u_idx_p0] <= upd_target;
      ctr_q[wr_way_p0][u_idx_p0] <= wr_ctr_p0;
    end
  end

  // ---- stage p1: registered prediction, held while lookup_en is low ----
  logic        hit_p1;
  logic        taken_p1;
  logic [31:0] tgt_p1;

  // Prediction register: zero on reset, load on lookup_en, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      tgt_p1   <= 32'h0;
    end else if (lookup_en) begin
      hit_p1   <= hit_nx_p0;
      taken_p1 <= taken_nx_p0;
      tgt_p1   <= tgt_nx_p0;
    end
  end

  assign hit         = hit_p1;
  assign pred_taken  = taken_p1;
  assign pred_target = tgt_p1;

endmodule
